// File: rtl/mips_32_pkg.sv
// Shared definitions for the mips_32 core: opcodes, instruction classes,
// instruction field positions and the bubble encoding.
package mips_32_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_AW    = 5;
    localparam int MEM_AW    = 10;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int REG_COUNT = 1 << REG_AW;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Unassigned opcode, so it decodes as NOP wherever it lands.
    localparam logic [DATA_W-1:0] BUBBLE_INSTR = 32'hF800_0000;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT,
        NOP
    } instr_type_e;

    function automatic instr_type_e decode_type(input logic [5:0] opc);
        instr_type_e t;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
            OP_LW:                                         t = LOAD;
            OP_SW:                                         t = STORE;
            OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
            OP_HLT:                                        t = HALT;
            default:                                       t = NOP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips_32_if.sv
// Status bundle of the mips_32 core: halt flag, branch pulse and program counter.
interface mips_32_if;
    import mips_32_pkg::*;

    logic              halted;
    logic              taken_branch;
    logic [DATA_W-1:0] pc;

    modport master (output halted, taken_branch, pc);
    modport slave  (input  halted, taken_branch, pc);
endinterface

// File: rtl/mips_32_alu.sv
// Combinational execute unit; loads and stores reuse the add path for address generation.
module mips_32_alu
    import mips_32_pkg::*;
(
    input  logic [5:0]               opcode,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_SUB, OP_SUBI:               result = a - b;
            OP_AND:                        result = a & b;
            OP_OR:                         result = a | b;
            OP_SLT, OP_SLTI:               result = (a < b) ? 32'sd1 : 32'sd0;
            OP_MUL:                        result = a * b;
            default:                       result = '0;
        endcase
    end

endmodule

// File: rtl/mips_32.sv
// Five-stage in-order mips_32 core with unified memory, EX-stage branch
// resolution, EX/MEM and MEM/WB forwarding and a sticky halt.
module mips_32
    import mips_32_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    output logic     halted,
    mips_32_if.master status
);

    logic [DATA_W-1:0] regfile [0:REG_COUNT-1];
    logic [DATA_W-1:0] mem     [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] PC;
    logic              HALTED;
    logic              TAKEN_BRANCH;
    logic              halt_pend;

    logic [DATA_W-1:0] ir_p0, npc_p0;
    logic              vld_p0;

    logic              vld_p1, we_p1;
    instr_type_e       itype_p1;
    logic [5:0]        opc_p1;
    logic [REG_AW-1:0] rs_p1, rt_p1, dst_p1;
    logic signed [DATA_W-1:0] a_p1, b_p1, imm_p1;
    logic [DATA_W-1:0] npc_p1;

    logic              vld_p2, we_p2;
    instr_type_e       itype_p2;
    logic [REG_AW-1:0] dst_p2;
    logic signed [DATA_W-1:0] alu_p2, sd_p2;

    logic              vld_p3, we_p3;
    instr_type_e       itype_p3;
    logic [REG_AW-1:0] dst_p3;
    logic signed [DATA_W-1:0] res_p3;

    logic [5:0]        opc_id;
    logic [REG_AW-1:0] rs_id, rt_id, rd_id, dst_id;
    logic signed [DATA_W-1:0] imm_id, a_id, b_id;
    instr_type_e       itype_id;
    logic              we_id, halt_id;

    logic signed [DATA_W-1:0] a_ex, b_ex, alu_b, alu_res;
    logic              taken_ex, fw_p2, wb_we, fetch_bubble;
    logic [DATA_W-1:0] target_ex;
    logic signed [DATA_W-1:0] res_mem;

    // ---- ID: decode and register read (WB write is visible here)
    assign opc_id   = ir_p0[OPC_HI:OPC_LO];
    assign rs_id    = ir_p0[RS_HI:RS_LO];
    assign rt_id    = ir_p0[RT_HI:RT_LO];
    assign rd_id    = ir_p0[RD_HI:RD_LO];
    assign imm_id   = {{(DATA_W-16){ir_p0[IMM_HI]}}, ir_p0[IMM_HI:IMM_LO]};
    assign itype_id = vld_p0 ? decode_type(opc_id) : NOP;
    assign dst_id   = (itype_id == RR_ALU) ? rd_id : rt_id;
    assign we_id    = ((itype_id == RR_ALU) || (itype_id == RM_ALU) || (itype_id == LOAD))
                      && (dst_id != '0);
    assign halt_id  = (itype_id == HALT);
    assign wb_we    = vld_p3 && we_p3;

    always_comb begin
        a_id = '0;
        b_id = '0;
        if (rs_id != '0) a_id = (wb_we && dst_p3 == rs_id) ? res_p3 : regfile[rs_id];
        if (rt_id != '0) b_id = (wb_we && dst_p3 == rt_id) ? res_p3 : regfile[rt_id];
    end

    // ---- EX: forwarding (loads in EX/MEM are not forwarded), ALU, branch resolve
    assign fw_p2 = vld_p2 && we_p2 && (itype_p2 != LOAD);

    always_comb begin
        a_ex = a_p1;
        b_ex = b_p1;
        if (fw_p2 && dst_p2 == rs_p1)      a_ex = alu_p2;
        else if (wb_we && dst_p3 == rs_p1) a_ex = res_p3;
        if (fw_p2 && dst_p2 == rt_p1)      b_ex = alu_p2;
        else if (wb_we && dst_p3 == rt_p1) b_ex = res_p3;
    end

    assign alu_b = (itype_p1 == RR_ALU) ? b_ex : imm_p1;

    mips_32_alu u_alu (
        .opcode (opc_p1),
        .a      (a_ex),
        .b      (alu_b),
        .result (alu_res)
    );

    assign taken_ex  = vld_p1 && (itype_p1 == BRANCH) &&
                       ((opc_p1 == OP_BEQZ) ? (a_ex == '0) : (a_ex != '0));
    assign target_ex = npc_p1 + imm_p1;

    // ---- MEM: load data select
    assign res_mem = (itype_p2 == LOAD) ? mem[alu_p2[MEM_AW-1:0]] : alu_p2;

    assign fetch_bubble = taken_ex || halt_pend || halt_id;

    // Control state: the only registers cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            halt_pend    <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            vld_p3       <= 1'b0;
        end else begin
            TAKEN_BRANCH <= taken_ex;
            vld_p2       <= vld_p1;
            vld_p3       <= vld_p2;
            if (vld_p3 && itype_p3 == HALT) HALTED <= 1'b1;
            if (taken_ex) begin
                PC     <= target_ex;
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                if (halt_pend || halt_id) begin
                    halt_pend <= 1'b1;
                    vld_p0    <= 1'b0;
                end else begin
                    PC     <= PC + 32'd1;
                    vld_p0 <= 1'b1;
                end
            end
        end
    end

    // Datapath stage registers; validity is carried by vld_pN.
    always_ff @(posedge clk) begin
        ir_p0    <= fetch_bubble ? BUBBLE_INSTR : mem[PC[MEM_AW-1:0]];
        npc_p0   <= PC + 32'd1;

        itype_p1 <= itype_id;
        opc_p1   <= opc_id;
        rs_p1    <= rs_id;
        rt_p1    <= rt_id;
        dst_p1   <= dst_id;
        we_p1    <= we_id;
        a_p1     <= a_id;
        b_p1     <= b_id;
        imm_p1   <= imm_id;
        npc_p1   <= npc_p0;

        itype_p2 <= itype_p1;
        dst_p2   <= dst_p1;
        we_p2    <= we_p1;
        alu_p2   <= alu_res;
        sd_p2    <= b_ex;

        itype_p3 <= itype_p2;
        dst_p3   <= dst_p2;
        we_p3    <= we_p2;
        res_p3   <= res_mem;
    end

    always @(posedge clk) begin
        if (wb_we) regfile[dst_p3] <= res_p3;
    end

    always @(posedge clk) begin
        if (vld_p2 && itype_p2 == STORE) mem[alu_p2[MEM_AW-1:0]] <= sd_p2;
    end

    assign halted              = HALTED;
    assign status.halted       = HALTED;
    assign status.taken_branch = TAKEN_BRANCH;
    assign status.pc           = PC;

endmodule

// File: tb/tb_mips_32.sv
// Directed program bench for mips_32: preloads memory/registers and runs each program to HLT.
module tb_mips_32;

    localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
    localparam logic [5:0] T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
    localparam logic [5:0] T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010;
    localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100;
    localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110, T_HLT = 6'b111111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic halted;
    int   checks = 0;
    int   passes = 0;

    mips_32_if bus ();

    mips_32 dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted),
        .status (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_hlt();
        return {T_HLT, 26'd0};
    endfunction

    task automatic prep();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 128; i++) dut.mem[i] = '0;
        for (int k = 0; k < 32; k++) dut.regfile[k] = 32'(k);
    endtask

    task automatic run_prog(input int max_cycles, output int cycles, output int taken);
        @(negedge clk);
        rst    = 1'b0;
        cycles = 0;
        taken  = 0;
        while (halted !== 1'b1 && cycles < max_cycles) begin
            @(posedge clk);
            #1;
            cycles++;
            if (dut.TAKEN_BRANCH === 1'b1) taken++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (dut.PC !== 32'd0) $display("FAIL reset_pc: got %0d want 0", dut.PC); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passes++;
        checks++; if (dut.TAKEN_BRANCH !== 1'b0) $display("FAIL reset_taken: got %b want 0", dut.TAKEN_BRANCH); else passes++;
    endtask

    task automatic test_alu_chain();
        int cyc, tk;
        logic [31:0] exp [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
        prep();
        dut.mem[0] = enc_i(T_ADDI, 1, 0, 10);
        dut.mem[1] = enc_i(T_ADDI, 2, 0, 20);
        dut.mem[2] = enc_i(T_ADDI, 3, 0, 25);
        dut.mem[3] = enc_r(T_ADD, 4, 1, 2);
        dut.mem[4] = enc_r(T_ADD, 5, 4, 3);
        dut.mem[5] = enc_hlt();
        run_prog(200, cyc, tk);
        checks++; if (halted !== 1'b1) $display("FAIL chain_halted: got %b want 1", halted); else passes++;
        for (int r = 0; r < 6; r++) begin
            checks++;
            if (dut.regfile[r] !== exp[r]) $display("FAIL chain_R%0d: got %0d want %0d", r, dut.regfile[r], exp[r]);
            else passes++;
        end
    endtask

    task automatic test_alu_ops();
        int cyc, tk;
        int          rr  [11] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
        logic [31:0] exp [11] = '{32'hFFFF_FFFE, 32'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd42,
                                  32'd1, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'hFFFF_FFF9};
        prep();
        dut.mem[0]  = enc_r(T_SUB, 10, 3, 5);
        dut.mem[1]  = enc_r(T_AND, 11, 6, 7);
        dut.mem[2]  = enc_r(T_OR, 12, 5, 10);
        dut.mem[3]  = enc_r(T_SLT, 13, 10, 1);
        dut.mem[4]  = enc_r(T_SLT, 14, 1, 10);
        dut.mem[5]  = enc_r(T_MUL, 15, 6, 7);
        dut.mem[6]  = enc_i(T_SLTI, 16, 10, -1);
        dut.mem[7]  = enc_i(T_SUBI, 17, 9, 10);
        dut.mem[8]  = enc_r(T_MUL, 18, 10, 10);
        dut.mem[9]  = enc_i(T_ADDI, 19, 17, 1);
        dut.mem[10] = enc_r(T_MUL, 20, 12, 7);
        dut.mem[11] = enc_hlt();
        run_prog(200, cyc, tk);
        checks++; if (halted !== 1'b1) $display("FAIL ops_halted: got %b want 1", halted); else passes++;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (dut.regfile[rr[i]] !== exp[i]) $display("FAIL ops_R%0d: got %h want %h", rr[i], dut.regfile[rr[i]], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_load_store();
        int cyc, tk;
        prep();
        dut.mem[120]   = 32'd85;
        dut.regfile[1] = 32'd120;
        dut.mem[0] = enc_i(T_LW, 2, 1, 0);
        dut.mem[1] = enc_r(T_OR, 7, 7, 7);
        dut.mem[2] = enc_i(T_ADDI, 2, 2, 45);
        dut.mem[3] = enc_i(T_SW, 2, 1, 1);
        dut.mem[4] = enc_hlt();
        run_prog(200, cyc, tk);
        checks++; if (halted !== 1'b1) $display("FAIL ls_halted: got %b want 1", halted); else passes++;
        checks++; if (dut.mem[121] !== 32'd130) $display("FAIL ls_mem121: got %0d want 130", dut.mem[121]); else passes++;
        checks++; if (dut.regfile[2] !== 32'd130) $display("FAIL ls_R2: got %0d want 130", dut.regfile[2]); else passes++;
    endtask

    task automatic test_load_use();
        int cyc, tk;
        prep();
        dut.mem[120]   = 32'd85;
        dut.regfile[1] = 32'd120;
        dut.regfile[2] = 32'd7;
        dut.mem[0] = enc_i(T_LW, 2, 1, 0);
        dut.mem[1] = enc_r(T_ADD, 3, 2, 0);
        dut.mem[2] = enc_hlt();
        run_prog(200, cyc, tk);
        checks++; if (halted !== 1'b1) $display("FAIL lu_halted: got %b want 1", halted); else passes++;
        checks++; if (dut.regfile[3] !== 32'd7) $display("FAIL lu_R3: got %0d want 7", dut.regfile[3]); else passes++;
        checks++; if (dut.regfile[2] !== 32'd85) $display("FAIL lu_R2: got %0d want 85", dut.regfile[2]); else passes++;
    endtask

    task automatic test_loop();
        int cyc, tk;
        prep();
        dut.regfile[1] = 32'd5;
        dut.regfile[2] = 32'd0;
        dut.mem[0] = enc_r(T_ADD, 2, 2, 1);
        dut.mem[1] = enc_i(T_SUBI, 1, 1, 1);
        dut.mem[2] = enc_i(T_BNEQZ, 0, 1, -3);
        dut.mem[3] = enc_hlt();
        dut.mem[4] = enc_i(T_ADDI, 20, 0, 77);
        run_prog(400, cyc, tk);
        checks++; if (halted !== 1'b1) $display("FAIL loop_halted: got %b want 1", halted); else passes++;
        checks++; if (dut.regfile[2] !== 32'd15) $display("FAIL loop_R2: got %0d want 15", dut.regfile[2]); else passes++;
        checks++; if (dut.regfile[1] !== 32'd0) $display("FAIL loop_R1: got %0d want 0", dut.regfile[1]); else passes++;
        checks++; if (dut.regfile[20] !== 32'd20) $display("FAIL loop_shadow_R20: got %0d want 20", dut.regfile[20]); else passes++;
        checks++; if (tk !== 4) $display("FAIL loop_taken_pulses: got %0d want 4", tk); else passes++;
    endtask

    task automatic test_branch_halt();
        int cyc, tk;
        prep();
        dut.mem[0] = enc_i(T_BNEQZ, 0, 0, 5);
        dut.mem[1] = enc_i(T_BEQZ, 0, 0, 2);
        dut.mem[2] = enc_i(T_ADDI, 8, 0, 1);
        dut.mem[3] = enc_i(T_ADDI, 9, 0, 1);
        dut.mem[4] = enc_hlt();
        dut.mem[5] = enc_i(T_ADDI, 6, 0, 99);
        run_prog(200, cyc, tk);
        checks++; if (halted !== 1'b1) $display("FAIL br_halted: got %b want 1", halted); else passes++;
        checks++; if (dut.regfile[8] !== 32'd8) $display("FAIL br_R8: got %0d want 8", dut.regfile[8]); else passes++;
        checks++; if (dut.regfile[9] !== 32'd9) $display("FAIL br_R9: got %0d want 9", dut.regfile[9]); else passes++;
        checks++; if (tk !== 1) $display("FAIL br_taken_pulses: got %0d want 1", tk); else passes++;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (dut.regfile[6] !== 32'd6) $display("FAIL hlt_R6: got %0d want 6", dut.regfile[6]); else passes++;
        checks++; if (dut.PC !== 32'd5) $display("FAIL hlt_pc_frozen: got %0d want 5", dut.PC); else passes++;
        checks++; if (halted !== 1'b1) $display("FAIL hlt_sticky: got %b want 1", halted); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) $display("FAIL hlt_reset_halted: got %b want 0", halted); else passes++;
        checks++; if (dut.PC !== 32'd0) $display("FAIL hlt_reset_pc: got %0d want 0", dut.PC); else passes++;
    endtask

    task automatic test_timing();
        prep();
        for (int i = 0; i < 8; i++) dut.mem[i] = enc_i(T_ADDI, 21 + i, 0, i + 1);
        dut.mem[8] = enc_hlt();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (halted !== 1'b0) $display("FAIL tim_edge12: got %b want 0", halted); else passes++;
        @(posedge clk);
        #1;
        checks++; if (halted !== 1'b1) $display("FAIL tim_edge13: got %b want 1", halted); else passes++;
        checks++; if (dut.regfile[28] !== 32'd8) $display("FAIL tim_R28: got %0d want 8", dut.regfile[28]); else passes++;
    endtask

    task automatic test_reset_midrun();
        int r1, r2, s_hi, s_lo, cyc;
        logic ok;
        prep();
        dut.regfile[1] = 32'd50;
        dut.regfile[2] = 32'd0;
        dut.mem[0] = enc_r(T_ADD, 2, 2, 1);
        dut.mem[1] = enc_i(T_SUBI, 1, 1, 1);
        dut.mem[2] = enc_i(T_BNEQZ, 0, 1, -3);
        dut.mem[3] = enc_hlt();
        @(negedge clk);
        rst = 1'b0;
        repeat (23) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (dut.PC !== 32'd0) $display("FAIL mid_pc: got %0d want 0", dut.PC); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL mid_halted: got %b want 0", halted); else passes++;
        checks++; if (dut.TAKEN_BRANCH !== 1'b0) $display("FAIL mid_taken: got %b want 0", dut.TAKEN_BRANCH); else passes++;
        repeat (3) @(posedge clk);
        #1;
        r1   = int'(dut.regfile[1]);
        r2   = int'(dut.regfile[2]);
        s_hi = 1275 - (r1 * (r1 + 1)) / 2;
        s_lo = 1275 - ((r1 - 1) * r1) / 2;
        ok   = (r1 >= 1) && (r1 <= 49) && ((r2 == s_hi) || (r2 == s_lo));
        checks++; if (!ok) $display("FAIL mid_regs_retained: got R1=%0d R2=%0d want consistent partial sum", r1, r2); else passes++;
        checks++; if (dut.regfile[9] !== 32'd9) $display("FAIL mid_R9: got %0d want 9", dut.regfile[9]); else passes++;
        dut.mem[0] = enc_i(T_ADDI, 0, 0, 5);
        dut.mem[1] = enc_i(T_ADDI, 3, 0, 4);
        dut.mem[2] = enc_hlt();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (dut.PC !== 32'd1) $display("FAIL restart_pc: got %0d want 1", dut.PC); else passes++;
        cyc = 0;
        while (halted !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++; if (halted !== 1'b1) $display("FAIL restart_halted: got %b want 1", halted); else passes++;
        checks++; if (dut.regfile[0] !== 32'd0) $display("FAIL r0_write: got %0d want 0", dut.regfile[0]); else passes++;
        checks++; if (dut.regfile[3] !== 32'd4) $display("FAIL r0_fwd_R3: got %0d want 4", dut.regfile[3]); else passes++;
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_alu_ops();
        test_load_store();
        test_load_use();
        test_loop();
        test_branch_halt();
        test_timing();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_32.md
# mips_32

Five-stage in-order pipelined processor (IF, ID, EX, MEM, WB) for a 32-bit MIPS-like subset. It has a unified word-addressed instruction/data memory, a 32×32 register file and a halt flag. It is the top-level core of the power-estimation design. Benches preload program and data hierarchically, then run it to HLT.

## Interface
- No parameters. Fixed sizes: 32 registers × 32 bits, memory 1024 × 32 bits.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `halted` output 1 — high once HLT has retired.
- Hierarchically accessible state, names fixed for benches: `regfile[0:31]`, `mem[0:1023]`, `PC`, `HALTED`, `TAKEN_BRANCH`.

## Operation
- Instruction fields:
  - [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
  - imm is sign-extended to 32 bits.
- Opcodes:
  - ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101: rd ← rs op rt.
  - ADDI 001010, SUBI 001011, SLTI 001100: rt ← rs op imm.
  - LW 001000: rt ← mem[rs+imm].
  - SW 001001: mem[rs+imm] ← rt.
  - BNEQZ 001101, BEQZ 001110: branch when rs≠0 / rs=0.
  - HLT 111111.
  - Any other opcode executes as a NOP.
- Arithmetic:
  - ADD/SUB/ADDI/SUBI wrap modulo 2^32.
  - MUL keeps the low 32 bits.
  - SLT/SLTI compare signed and write 1 or 0.
  - Memory addresses use bits [9:0] of rs+imm.
- Register 0 reads as 0; writes to it are discarded.
- Register file writes first: a WB write is visible to an ID read in the same cycle.
- Forwarding into the EX operands (rs, rt and store data):
  - From EX/MEM (ALU result).
  - From MEM/WB (ALU result or load data).
  - Youngest source wins.
- No load-use interlock. The instruction directly after LW gets the register value from before the load. The second instruction after LW gets the loaded value.
- Branches:
  - Resolved in EX; the condition uses forwarded rs.
  - Target = (branch address + 1) + sext(imm).
  - Taken: PC ← target, `TAKEN_BRANCH` pulses for one cycle, and the two younger instructions (in IF/ID and ID/EX) become bubbles.
  - Not taken: no penalty.
- HLT:
  - When HLT is decoded, fetch stops, PC freezes and bubbles are inserted, so nothing after HLT commits.
  - When HLT reaches WB, `HALTED`/`halted` ← 1. It stays 1 until reset.
  - When HLT sits in the shadow of a taken branch, it is flushed like any other instruction.
- Reset (asynchronous):
  - `PC`=0, `HALTED`=0, `TAKEN_BRANCH`=0.
  - All pipeline registers become bubbles; `halted`=0.
  - `regfile` and `mem` are not reset.
  - Reset asserted mid-run aborts every in-flight instruction with no partial writes. Execution restarts at address 0 on the first edge after release.

## Timing
- One instruction issued per cycle.
- Instruction fetched on edge n: writes regfile/memory on edge n+4 (SW commits on edge n+3).
- Dependent instructions may be back-to-back, except a consumer immediately after LW.
- Taken branch costs 2 cycles.
- `halted` rises on the edge where HLT leaves WB, 4 edges after HLT is fetched.
  - Example: 9-instruction straight-line program with HLT at address 8 → `halted`=1 after edge 13 counted from reset release.

## Structure
- Package `mips_32_pkg`:
  - opcode localparams;
  - instruction-type enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP;
  - field bit positions;
  - a bubble/NOP constant.
- Sub-module `mips_32_alu`: combinational, takes opcode and two operands, returns the result.
- Pipeline registers, forwarding, flush and halt control stay in the top module.

## Test plan
- Preload `regfile[k]`=k, then run ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; ADD R4,R1,R2; ADD R5,R4,R3; HLT (no dummies).
  - Required: R0..R5 = 0,10,20,25,30,55 and `halted`=1.
- LW/SW: `mem[120]`=85, R1=120. Run LW R2,0(R1); OR R7,R7,R7; ADDI R2,R2,45; SW R2,1(R1); HLT.
  - Required: `mem[121]`=130.
- Load-use: LW R2,0(R1) immediately followed by ADD R3,R2,R0, with R2=7 beforehand and `mem[120]`=85.
  - Required: R3=7 and R2=85.
- Loop: R1=5, R2=0. Loop body ADD R2,R2,R1; SUBI R1,R1,1; BNEQZ R1,−3; then HLT.
  - Required: R2=15, R1=0, and shadow instructions never commit.
- Branch and halt:
  - BEQZ R0,+2 skipping ADDI R8,R0,1 and ADDI R9,R0,1 → R8=8, R9=9 unchanged.
  - HLT followed by ADDI R6,R0,99 → R6=6 unchanged, PC frozen.
- Reset: assert `rst` between edges mid-loop.
  - Required: `PC`=0 and `halted`=0 immediately, `regfile` retained.
  - Required: ADDI R0,R0,5 leaves R0 reading 0.
